// File: rtl/parity_engine.sv
// Frame parity generator/checker for the UART datapath: accumulates parity over
// WIDTH-bit beats and emits a one-cycle result strobe with a saturating error count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for the first beat of a frame; config latched on accept
// ST_ACCUM  | mid-frame, folding accepted beats into the accumulator
// ST_RESULT | one-cycle result strobe; no beat accepted
module parity_engine #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           cfg_mode_in,
    input  logic                 cfg_check_in,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 data_valid_in,
    input  logic                 data_last_in,
    input  logic                 par_in,
    input  logic                 err_clr_in,
    output logic                 ready_out,
    output logic                 busy_out,
    output logic                 par_bit_out,
    output logic                 par_valid_out,
    output logic                 par_err_out,
    output logic [ERR_CNT_W-1:0] err_cnt_out
);

    localparam logic [2:0] MODE_EVEN  = 3'd1;
    localparam logic [2:0] MODE_ODD   = 3'd2;
    localparam logic [2:0] MODE_MARK  = 3'd3;
    localparam logic [2:0] MODE_SPACE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             mode_q, mode_d;
    logic                   check_q, check_d;
    logic                   acc_q, acc_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_valid_q, par_valid_d;
    logic                   par_err_q, par_err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                   accept;
    logic                   beat_par;
    logic                   acc_new;
    logic [2:0]             frame_mode;
    logic                   frame_check;
    logic                   mode_active;
    logic                   exp_par;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        check_d     = check_q;
        acc_d       = acc_q;
        par_bit_d   = par_bit_q;
        par_valid_d = 1'b0;
        par_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;

        accept   = data_valid_in && (state_q != ST_RESULT);
        beat_par = ^data_in;

        // A single-beat frame finishes in IDLE, so the live config/accumulator is used there.
        frame_mode  = (state_q == ST_IDLE) ? cfg_mode_in  : mode_q;
        frame_check = (state_q == ST_IDLE) ? cfg_check_in : check_q;
        acc_new     = (state_q == ST_IDLE) ? beat_par     : (acc_q ^ beat_par);

        mode_active = (frame_mode == MODE_EVEN) || (frame_mode == MODE_ODD) ||
                      (frame_mode == MODE_MARK) || (frame_mode == MODE_SPACE);

        case (frame_mode)
            MODE_EVEN: exp_par = acc_new;
            MODE_ODD:  exp_par = ~acc_new;
            MODE_MARK: exp_par = 1'b1;
            default:   exp_par = 1'b0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mode_d  = cfg_mode_in;
                    check_d = cfg_check_in;
                    acc_d   = acc_new;
                    state_d = data_last_in ? ST_RESULT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = acc_new;
                    if (data_last_in) state_d = ST_RESULT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && data_last_in) begin
            par_valid_d = 1'b1;
            par_bit_d   = exp_par;
            par_err_d   = frame_check && mode_active && (par_in != exp_par);
        end

        if (err_clr_in)
            err_cnt_d = '0;
        else if (par_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= 3'd0;
            check_q     <= 1'b0;
            acc_q       <= 1'b0;
            par_bit_q   <= 1'b0;
            par_valid_q <= 1'b0;
            par_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            check_q     <= check_d;
            acc_q       <= acc_d;
            par_bit_q   <= par_bit_d;
            par_valid_q <= par_valid_d;
            par_err_q   <= par_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign ready_out     = (state_q != ST_RESULT);
    assign busy_out      = (state_q != ST_IDLE);
    assign par_bit_out   = par_bit_q;
    assign par_valid_out = par_valid_q;
    assign par_err_out   = par_err_q;
    assign err_cnt_out   = err_cnt_q;

endmodule
